// File: rtl/hash_mem_pkg.sv
// Shared constants and types for the hash memory responder and its result tracker.
package hash_mem_pkg;

  localparam int          ADDR_W         = 16;
  localparam int          NUM_NONCES_DEF = 16;
  localparam logic [31:0] BEST_HASH_RST  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    TRK_IDLE  = 2'd0,
    TRK_ARMED = 2'd1,
    TRK_DONE  = 2'd2
  } trk_state_e;

endpackage

// File: rtl/hash_mem_responder_tracker.sv
// Result tracker: watches engine writes into the output window, keeps a slot bitmap,
// a distinct-slot count and (with HASH_MEM_BEST_TRACK_EN) the minimum word written.
//
// state     | meaning
// TRK_IDLE  | not capturing since reset
// TRK_ARMED | capturing writes into the window
// TRK_DONE  | every slot written; outputs frozen until the next arm
module hash_result_tracker
  import hash_mem_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEF,
  parameter int NW         = $clog2(NUM_NONCES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic [ADDR_W-1:0] out_base,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              results_done,
  output logic [NW:0]       write_count,
  output logic [31:0]       best_hash,
  output logic [NW-1:0]     best_nonce
);

  trk_state_e              state_q, state_d;
  logic [NUM_NONCES-1:0]   bitmap_q, bitmap_d;
  logic [NW:0]             count_q, count_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic                    in_window;
  logic                    hit;
  logic [NW-1:0]           slot;

  // Upper bound in 17 bits so a window near 16'hFFFF never wraps to low addresses.
  assign in_window = ({1'b0, wr_addr} >= {1'b0, base_q}) &&
                     ({1'b0, wr_addr} <  ({1'b0, base_q} + 17'(NUM_NONCES)));
  assign hit       = wr_en && in_window && (state_q == TRK_ARMED);
  assign slot      = wr_addr[NW-1:0] - base_q[NW-1:0];

  always_comb begin
    state_d  = state_q;
    bitmap_d = bitmap_q;
    count_d  = count_q;
    base_d   = base_q;
    if (arm) begin
      state_d  = TRK_ARMED;
      bitmap_d = '0;
      count_d  = '0;
      base_d   = out_base;
    end else if (hit) begin
      if (!bitmap_q[slot]) begin
        bitmap_d[slot] = 1'b1;
        count_d        = count_q + 1'b1;
      end
      if (&bitmap_d) state_d = TRK_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= TRK_IDLE;
      bitmap_q <= '0;
      count_q  <= '0;
      base_q   <= '0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
      count_q  <= count_d;
      base_q   <= base_d;
    end
  end

  assign results_done = (state_q == TRK_DONE);
  assign write_count  = count_q;

`ifdef HASH_MEM_BEST_TRACK_EN
  logic [31:0]   best_hash_q, best_hash_d;
  logic [NW-1:0] best_nonce_q, best_nonce_d;

  // Strict compare: ties keep the earlier slot; rewrites can only lower the best.
  always_comb begin
    best_hash_d  = best_hash_q;
    best_nonce_d = best_nonce_q;
    if (arm) begin
      best_hash_d  = BEST_HASH_RST;
      best_nonce_d = '0;
    end else if (hit && (wr_data < best_hash_q)) begin
      best_hash_d  = wr_data;
      best_nonce_d = slot;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_hash_q  <= BEST_HASH_RST;
      best_nonce_q <= '0;
    end else begin
      best_hash_q  <= best_hash_d;
      best_nonce_q <= best_nonce_d;
    end
  end

  assign best_hash  = best_hash_q;
  assign best_nonce = best_nonce_q;
`else
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data;
  assign best_hash      = BEST_HASH_RST;
  assign best_nonce     = '0;
`endif

endmodule

// File: rtl/hash_mem_responder.sv
// Word memory shared by the hashing engine and a host port, with sticky out-of-range flag
// and an integrated result tracker. Optional best-hash tracking: HASH_MEM_BEST_TRACK_EN.
module hash_mem_responder
  import hash_mem_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int NUM_NONCES = NUM_NONCES_DEF,
  parameter int NW         = $clog2(NUM_NONCES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              engine_active,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_write_data,
  output logic [31:0]       mem_read_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_gnt,
  output logic [31:0]       host_rdata,
  output logic              host_rvalid,
  input  logic [ADDR_W-1:0] out_base,
  input  logic              arm,
  output logic              results_done,
  output logic [NW:0]       write_count,
  output logic [31:0]       best_hash,
  output logic [NW-1:0]     best_nonce,
  output logic              oob_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]       mem_array [DEPTH];
  logic              acc_en, acc_we, in_range;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata, rd_word;
  logic [IW-1:0]     mem_idx;

  logic [31:0] mem_read_data_q, mem_read_data_d;
  logic [31:0] host_rdata_q, host_rdata_d;
  logic        host_rvalid_q, host_rvalid_d;
  logic        oob_err_q, oob_err_d;

  assign host_gnt = host_req & ~engine_active;

  // Single physical port; ownership switches with engine_active, no hand-over bubble.
  always_comb begin
    acc_en    = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    if (engine_active) begin
      acc_en    = 1'b1;
      acc_we    = mem_we;
      acc_addr  = mem_addr;
      acc_wdata = mem_write_data;
    end else if (host_gnt) begin
      acc_en    = 1'b1;
      acc_we    = host_we;
      acc_addr  = host_addr;
      acc_wdata = host_wdata;
    end
  end

  assign in_range = ({16'd0, acc_addr} < 32'(DEPTH));
  assign mem_idx  = acc_addr[IW-1:0];
  assign rd_word  = in_range ? mem_array[mem_idx] : 32'd0;

  always_ff @(posedge clk) begin
    if (acc_en && acc_we && in_range) mem_array[mem_idx] <= acc_wdata;
  end

  always_comb begin
    mem_read_data_d = engine_active ? rd_word : mem_read_data_q;
    host_rvalid_d   = host_gnt & ~host_we;
    host_rdata_d    = host_rvalid_d ? rd_word : host_rdata_q;
    oob_err_d       = oob_err_q | (acc_en & ~in_range);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data_q <= '0;
      host_rdata_q    <= '0;
      host_rvalid_q   <= 1'b0;
      oob_err_q       <= 1'b0;
    end else begin
      mem_read_data_q <= mem_read_data_d;
      host_rdata_q    <= host_rdata_d;
      host_rvalid_q   <= host_rvalid_d;
      oob_err_q       <= oob_err_d;
    end
  end

  assign mem_read_data = mem_read_data_q;
  assign host_rdata    = host_rdata_q;
  assign host_rvalid   = host_rvalid_q;
  assign oob_err       = oob_err_q;

  hash_result_tracker #(
    .NUM_NONCES (NUM_NONCES),
    .NW         (NW)
  ) u_tracker (
    .clk          (clk),
    .reset_n      (reset_n),
    .arm          (arm),
    .out_base     (out_base),
    .wr_en        (engine_active & mem_we),
    .wr_addr      (mem_addr),
    .wr_data      (mem_write_data),
    .results_done (results_done),
    .write_count  (write_count),
    .best_hash    (best_hash),
    .best_nonce   (best_nonce)
  );

endmodule

// File: tb/tb_hash_mem_responder.sv
// Directed bench for hash_mem_responder: port table plus tracker, oob and reset sequences.
module tb_hash_mem_responder;

`ifdef HASH_MEM_BEST_TRACK_EN
  localparam bit BT = 1'b1;
`else
  localparam bit BT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        engine_active, mem_we, host_req, host_we, arm;
  logic [15:0] mem_addr, host_addr, out_base;
  logic [31:0] mem_write_data, host_wdata;
  logic [31:0] mem_read_data, host_rdata, best_hash;
  logic        host_gnt, host_rvalid, results_done, oob_err;
  logic [4:0]  write_count;
  logic [3:0]  best_nonce;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hash_mem_responder #(.DEPTH(256), .NUM_NONCES(16)) dut (
    .clk(clk), .reset_n(reset_n), .engine_active(engine_active),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .out_base(out_base),
    .arm(arm), .results_done(results_done), .write_count(write_count),
    .best_hash(best_hash), .best_nonce(best_nonce), .oob_err(oob_err)
  );

  typedef struct {
    logic        eng;
    logic        mwe;
    logic [15:0] maddr;
    logic [31:0] mwdata;
    logic        hreq;
    logic        hwe;
    logic [15:0] haddr;
    logic [31:0] hwdata;
    logic        exp_gnt;
    logic [31:0] exp_mrd;
    logic [31:0] exp_hrd;
    logic        exp_hrv;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [31:0] d);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_rd(input logic [15:0] a);
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    tick();
    host_req = 1'b0;
  endtask

  task automatic eng_wr(input logic [15:0] a, input logic [31:0] d);
    engine_active = 1'b1; mem_we = 1'b1; mem_addr = a; mem_write_data = d;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic eng_rd(input logic [15:0] a);
    engine_active = 1'b1; mem_we = 1'b0; mem_addr = a;
    tick();
  endtask

  task automatic arm_pulse(input logic [15:0] b);
    arm = 1'b1; out_base = b;
    tick();
    arm = 1'b0;
  endtask

  task automatic chk_trk(input string name, input logic done, input logic [4:0] cnt,
                         input logic [31:0] bh, input logic [3:0] bn);
    chk({name, ".done"},  {31'd0, results_done}, {31'd0, done});
    chk({name, ".count"}, {27'd0, write_count},  {27'd0, cnt});
    chk({name, ".best"},  best_hash,  BT ? bh : 32'hFFFF_FFFF);
    chk({name, ".nonce"}, {28'd0, best_nonce}, BT ? {28'd0, bn} : 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'd0,  32'd0,        1'b1, 1'b0, 16'd5,  32'd0, 1'b1, 32'h0,         32'hDEAD_0005, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 16'd0,  32'd0,        1'b1, 1'b0, 16'd20, 32'd0, 1'b1, 32'h0,         32'hDEAD_0014, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 16'd0,  32'd0,        1'b1, 1'b0, 16'd0,  32'd0, 1'b1, 32'h0,         32'hDEAD_0000, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'd3,  32'd0,        1'b1, 1'b0, 16'd7,  32'd0, 1'b0, 32'hDEAD_0003, 32'hDEAD_0000, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'd12, 32'd0,        1'b0, 1'b0, 16'd0,  32'd0, 1'b0, 32'hDEAD_000C, 32'hDEAD_0000, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 16'd12, 32'h12345678, 1'b0, 1'b0, 16'd0,  32'd0, 1'b0, 32'hDEAD_000C, 32'hDEAD_0000, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'd12, 32'd0,        1'b0, 1'b0, 16'd0,  32'd0, 1'b0, 32'h12345678,  32'hDEAD_0000, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 16'd0,  32'd0,        1'b1, 1'b0, 16'd12, 32'd0, 1'b1, 32'h12345678,  32'h12345678,  1'b1};
    vecs[8] = '{1'b0, 1'b1, 16'd13, 32'h0000FFFF, 1'b1, 1'b0, 16'd13, 32'd0, 1'b1, 32'h12345678,  32'hDEAD_000D, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 16'd0,  32'd0,        1'b1, 1'b0, 16'd13, 32'd0, 1'b1, 32'h12345678,  32'hDEAD_000D, 1'b1};

    reset_n = 1'b0; engine_active = 1'b0; mem_we = 1'b0; host_req = 1'b0; host_we = 1'b0;
    arm = 1'b0; mem_addr = '0; host_addr = '0; out_base = '0; mem_write_data = '0; host_wdata = '0;
    tick(); tick();
    chk("rst.mem_read_data", mem_read_data, 32'd0);
    chk("rst.host_rdata", host_rdata, 32'd0);
    chk("rst.host_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rst.oob_err", {31'd0, oob_err}, 32'd0);
    chk_trk("rst", 1'b0, 5'd0, 32'hFFFF_FFFF, 4'd0);
    chk("rst.best_raw", best_hash, 32'hFFFF_FFFF);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i <= 20; i++) host_wr(16'(i), 32'hDEAD_0000 + 32'(i));

    for (int i = 0; i < 10; i++) begin
      engine_active = vecs[i].eng; mem_we = vecs[i].mwe; mem_addr = vecs[i].maddr;
      mem_write_data = vecs[i].mwdata; host_req = vecs[i].hreq; host_we = vecs[i].hwe;
      host_addr = vecs[i].haddr; host_wdata = vecs[i].hwdata;
      #1;
      chk($sformatf("vec%0d.host_gnt", i), {31'd0, host_gnt}, {31'd0, vecs[i].exp_gnt});
      tick();
      chk($sformatf("vec%0d.mem_read_data", i), mem_read_data, vecs[i].exp_mrd);
      chk($sformatf("vec%0d.host_rdata", i), host_rdata, vecs[i].exp_hrd);
      chk($sformatf("vec%0d.host_rvalid", i), {31'd0, host_rvalid}, {31'd0, vecs[i].exp_hrv});
    end
    mem_we = 1'b0; host_req = 1'b0;

    // Full capture, slots written 15 down to 0
    engine_active = 1'b1;
    arm_pulse(16'h0080);
    chk_trk("arm1", 1'b0, 5'd0, 32'hFFFF_FFFF, 4'd0);
    for (int k = 15; k >= 0; k--) begin
      eng_wr(16'h0080 + 16'(k), 32'h1000 - 32'(k) * 32'h10);
      if (k == 1) chk_trk("cap15", 1'b0, 5'd15, 32'h0F10, 4'd15);
    end
    chk_trk("cap16", 1'b1, 5'd16, 32'h0F10, 4'd15);
    eng_wr(16'h0083, 32'd0);
    chk_trk("done_frozen", 1'b1, 5'd16, 32'h0F10, 4'd15);
    eng_rd(16'h0083);
    chk("done_mem_write", mem_read_data, 32'd0);
    eng_rd(16'h008F);
    chk("slot15_mem", mem_read_data, 32'h0F10);

    // Duplicate slot, missing slot, ties, rewrites and out-of-window writes
    arm_pulse(16'h0080);
    chk_trk("arm2", 1'b0, 5'd0, 32'hFFFF_FFFF, 4'd0);
    for (int k = 0; k < 4; k++) eng_wr(16'h0080 + 16'(k), 32'h2000 + 32'(k));
    eng_wr(16'h0084, 32'h0500);
    chk_trk("slot4_first", 1'b0, 5'd5, 32'h0500, 4'd4);
    eng_wr(16'h0084, 32'h0050);
    chk_trk("slot4_again", 1'b0, 5'd5, 32'h0050, 4'd4);
    for (int k = 5; k < 16; k++) if (k != 9) eng_wr(16'h0080 + 16'(k), (k == 10) ? 32'h0050 : 32'h2000 + 32'(k));
    eng_wr(16'h0084, 32'h0900);
    eng_wr(16'h007F, 32'h1);
    eng_wr(16'h0090, 32'h2);
    chk_trk("skip9", 1'b0, 5'd15, 32'h0050, 4'd4);
    eng_wr(16'h0089, 32'h3000);
    chk_trk("slot9", 1'b1, 5'd16, 32'h0050, 4'd4);
    eng_rd(16'h007F);
    chk("below_window_mem", mem_read_data, 32'h1);
    eng_rd(16'h0090);
    chk("above_window_mem", mem_read_data, 32'h2);

    // Arm beats a same-cycle hit
    arm = 1'b1; out_base = 16'h0080; mem_we = 1'b1; mem_addr = 16'h0080; mem_write_data = 32'h7;
    tick();
    arm = 1'b0; mem_we = 1'b0;
    chk_trk("arm_priority", 1'b0, 5'd0, 32'hFFFF_FFFF, 4'd0);
    eng_wr(16'h0081, 32'hAB);
    eng_wr(16'h0082, 32'hAC);
    chk_trk("rearmed", 1'b0, 5'd2, 32'hAB, 4'd1);

    // Out-of-range host accesses
    engine_active = 1'b0;
    host_wr(16'h00FF, 32'hAAAA);
    chk("oob_before", {31'd0, oob_err}, 32'd0);
    host_wr(16'h01FF, 32'h5555);
    chk("oob_set", {31'd0, oob_err}, 32'd1);
    host_rd(16'h01FF);
    chk("oob_read_zero", host_rdata, 32'd0);
    chk("oob_read_valid", {31'd0, host_rvalid}, 32'd1);
    host_rd(16'h00FF);
    chk("oob_write_dropped", host_rdata, 32'hAAAA);
    chk("oob_sticky", {31'd0, oob_err}, 32'd1);

    // Reset mid-capture
    engine_active = 1'b1;
    arm_pulse(16'h0080);
    eng_wr(16'h0085, 32'hCD);
    chk_trk("pre_reset", 1'b0, 5'd1, 32'hCD, 4'd5);
    reset_n = 1'b0;
    #2;
    chk_trk("in_reset", 1'b0, 5'd0, 32'hFFFF_FFFF, 4'd0);
    chk("reset_oob", {31'd0, oob_err}, 32'd0);
    chk("reset_mrd", mem_read_data, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    eng_rd(16'h0081);
    chk("mem_kept_0081", mem_read_data, 32'hAB);
    eng_rd(16'h0085);
    chk("mem_kept_0085", mem_read_data, 32'hCD);
    eng_wr(16'h0086, 32'h1);
    chk_trk("idle_ignores", 1'b0, 5'd0, 32'hFFFF_FFFF, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_mem_responder.md
# hash_mem_responder

Word-addressed memory responder that serves the hashing engine's memory port (`mem_we`, `mem_addr`, `mem_write_data`, `mem_read_data`). Reads have a fixed one-cycle latency. A host port loads message blocks and reads back results while the engine is inactive. An integrated result tracker watches engine writes into the output window and signals when every nonce slot has been written.

## Interface
Parameters:
- DEPTH, 256: memory size in 32-bit words; addresses >= DEPTH are out of range.
- NUM_NONCES, 16: number of output slots tracked; power of two, 2..64.
- NW, $clog2(NUM_NONCES): nonce index width.

Ports:
- clk  in  1  clock; the engine's mem_clk is this same clock.
- reset_n  in  1  reset, asynchronous, active-low.
- engine_active  in  1  high: engine port owns the memory. Low: host port owns it.
- mem_we  in  1  engine write enable.
- mem_addr  in  16  engine word address.
- mem_write_data  in  32  engine write data.
- mem_read_data  out  32  engine read data; registered.
- host_req  in  1  host access request.
- host_we  in  1  host write (1) or read (0).
- host_addr  in  16  host word address.
- host_wdata  in  32  host write data.
- host_gnt  out  1  combinational: host_req & !engine_active.
- host_rdata  out  32  host read data; registered.
- host_rvalid  out  1  high for exactly one cycle, the cycle after a granted host read.
- out_base  in  16  first address of the output window; sampled on arm.
- arm  in  1  one-cycle pulse; clears the tracker and starts capture.
- results_done  out  1  level; all NUM_NONCES slots have been written since the last arm.
- write_count  out  NW+1  number of distinct slots written since arm.
- best_hash  out  32  minimum word written into the window since arm.
- best_nonce  out  NW  slot index of best_hash.
- oob_err  out  1  sticky; set by any granted access with address >= DEPTH.

## Operation
- Memory array is not reset; its contents are undefined after power-up.
- Engine port:
  - Active only while engine_active=1. When engine_active=0, mem_we is ignored and mem_read_data holds its value.
  - A write commits at the clock edge where mem_we=1.
  - A read of mem_addr at edge N appears on mem_read_data after edge N+1 (one-cycle latency).
  - Read-during-write to the same address returns the old data (read-first).
- Host port: same rules as the engine port, applied to granted host cycles only. Ungranted host requests have no effect.
- Out-of-range access (either port): a write is dropped, a read returns 0, and oob_err is set. oob_err clears only on reset.
- Tracker state machine, states IDLE, ARMED, DONE:
  - IDLE -> ARMED on arm. Arming clears the slot bitmap, write_count, best_hash (set to 32'hFFFFFFFF), best_nonce and results_done, and latches out_base into the window base.
  - In ARMED, an engine write is a hit when base <= addr < base+NUM_NONCES. The window upper bound is computed in 17 bits, so the window never wraps past 16'hFFFF.
  - A hit sets bitmap[addr-base]. write_count increments only on the first write to a slot.
  - Best tracking: if the written value is strictly less than best_hash (unsigned), best_hash and best_nonce are updated. On ties the earlier write is kept. Rewriting a slot never restores a previous best.
  - ARMED -> DONE when the bitmap becomes all ones; results_done=1.
  - In DONE, writes update memory only; tracker outputs are frozen.
  - arm in any state restarts capture, and arm takes priority over a same-cycle hit.
- Host writes never affect the tracker.

## Timing
- Reset values: mem_read_data=0, host_rdata=0, host_rvalid=0, results_done=0, write_count=0, best_hash=32'hFFFFFFFF, best_nonce=0, oob_err=0, tracker state IDLE.
- Tracker outputs update at the same edge that commits the hit write; they are visible in the following cycle.
- results_done rises in the cycle after the final new-slot write.
- An engine_active toggle takes effect at the same cycle's edge; there is no hand-over bubble.
- Reset mid-capture returns the tracker to IDLE. Memory contents are preserved.

## Configuration
- HASH_MEM_BEST_TRACK_EN defined: best_hash/best_nonce comparator logic is built as described above.
- Not defined: best_hash is tied to 32'hFFFFFFFF and best_nonce to 0. Bitmap, write_count and results_done behave identically.

## Structure
- Package hash_mem_pkg holds:
  - the default NUM_NONCES and the address width constant (16);
  - the tracker state enum (TRK_IDLE, TRK_ARMED, TRK_DONE);
  - the best_hash reset constant 32'hFFFFFFFF.
- Sub-module hash_result_tracker contains the window compare, bitmap, counter and best comparator. The top level holds the memory array, port mux and oob logic.

## Test plan
- Host writes 0xDEAD0000+i to addresses 0..20, then host reads address 5 -> host_rvalid one cycle later with host_rdata=0xDEAD0005.
- engine_active=1, engine reads address 3 at edge N -> mem_read_data=0xDEAD0003 after edge N+1. host_req concurrent -> host_gnt=0.
- arm with out_base=0x80. Engine writes 16 slots in the order 15..0 with values 0x1000-i*0x10 -> results_done asserted the cycle after the 16th write, write_count=16, best_hash=0x0F10, best_nonce=15.
- Engine writes slot 4 twice, then skips slot 9 -> write_count=15 and results_done stays 0. Writing slot 9 -> results_done=1.
- Engine write to 0x7F and 0x90 with out_base=0x80 -> memory updated, tracker unchanged. Host write to 0x1FF with DEPTH=256 -> write dropped, oob_err=1 until reset.
- Assert reset_n mid-capture -> results_done=0, write_count=0, and previously written data still readable. Build without HASH_MEM_BEST_TRACK_EN -> best_hash constant at 0xFFFFFFFF.
